lfsr_gen: RTL and testbench
===========================

LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 16, LFSR state width; legal range 4..64.
REQ-002 Parameter OUT_W, default 8, bits emitted per output word; legal range 1..WIDTH.
REQ-003 Parameter SEED_DEFAULT, default 16'h0001 zero-extended to WIDTH, state after reset; SHALL be nonzero.
REQ-004 Parameter TAPS_DEFAULT, default 16'hD008 zero-extended to WIDTH, tap mask after reset.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 load  in  1  reinitialise: capture seed, taps, mode; flush output.
REQ-008 seed  in  WIDTH  initial state sampled on load.
REQ-009 taps  in  WIDTH  tap mask sampled on load.
REQ-010 mode  in  1  0 = Fibonacci, 1 = Galois; sampled on load.
REQ-011 en  in  1  permit generation of new words.
REQ-012 dout  out  OUT_W  output word; dout[OUT_W-1] is the first generated bit.
REQ-013 dout_valid  out  1  dout holds an unconsumed word.
REQ-014 dout_ready  in  1  consumer accepts dout when dout_valid.
REQ-015 state  out  WIDTH  current LFSR state register.
REQ-016 lockup  out  1  sticky: all-zero state was detected and recovered.
REQ-017 word_cnt  out  16  count of accepted words.

Function
REQ-018 One step, Fibonacci: bit = state[WIDTH-1]; fb = XOR-reduce(state & taps_q); state <= {state[WIDTH-2:0], fb}.
REQ-019 One step, Galois: bit = state[WIDTH-1]; state <= (state << 1) ^ (bit ? taps_q : 0), with bit also entering state[0] via the XOR term (taps_q[0] = 1 assumed of user).
REQ-020 Generation: when en && !load && (!dout_valid || dout_ready), OUT_W steps execute in one cycle; dout <= the OUT_W bits, MSB first; state <= state after OUT_W steps; dout_valid <= 1.
REQ-021 When !en && dout_valid && dout_ready: dout_valid <= 0; state unchanged.
REQ-022 Stall: dout_valid && !dout_ready: dout, dout_valid, state held stable.
REQ-023 Handshake: a word is accepted on a cycle with dout_valid && dout_ready; word_cnt increments by 1 and wraps 16'hFFFF -> 0.
REQ-024 Latency: first valid word appears the cycle after the first cycle with en high following reset or load.
REQ-025 load has priority over generation and acceptance: state <= seed, taps_q <= taps, mode_q <= mode, dout_valid <= 0, word_cnt <= 0; a word pending at load is discarded and not counted.
REQ-026 Lock-up: if the computed next state (from load or generation) is all zero, state <= 1 instead and lockup <= 1.
REQ-027 lockup clears only on load with nonzero seed; lockup is set if the seed is zero, even when load asserts while lockup is already set.
REQ-028 seed, taps and mode are ignored except on load; taps_q and mode_q are visible only through behaviour.

Reset
REQ-029 On rst_n low: state = SEED_DEFAULT, taps_q = TAPS_DEFAULT, mode_q = 0, dout = 0, dout_valid = 0, lockup = 0, word_cnt = 0, asynchronously.
REQ-030 Reset deassertion is synchronised externally; the first edge after release behaves as a normal cycle.

Structure
REQ-031 Package lfsr_pkg holds mode enum (LFSR_FIB, LFSR_GAL) and default tap constant.
REQ-032 Sub-module lfsr_step: combinational single step (state, taps, mode -> next state, bit); lfsr_gen instantiates OUT_W copies in a chain.

Verification
REQ-033 WIDTH=16, OUT_W=8, load seed=16'h00A5, taps=16'h8000, mode=0, en=1, ready=1 -> words 8'h00, 8'hA5, 8'h00, ...; state 16'hA500 after the first word.
REQ-034 Load seed=16'h0001, taps=16'hD008, mode=0, ready=1 -> state returns to 16'h0001 first after exactly 65535 accepted words; word_cnt=65535; lockup=0.
REQ-035 Load seed=16'h0001, taps=0, mode=0 -> word 2 computes zero state; state forced to 16'h0001, lockup=1 and held until a nonzero-seed load.
REQ-036 Hold dout_ready=0 for 3 cycles with dout_valid=1 -> dout, state and word_cnt stable; release -> word accepted, word_cnt+1.
REQ-037 Assert load while dout_valid=1, dout_ready=0 -> next cycle dout_valid=0, word_cnt=0, state=seed.
REQ-038 Assert rst_n low mid-stream, asynchronously between edges -> all outputs take reset values immediately; lockup=0.

Source files
------------

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Shared types and reset constants for the LFSR word generator.
//  Revision    : 1.0  initial release
// ============================================================================
package lfsr_pkg;

    // Feedback topology selected on load
    typedef enum logic {
        LFSR_FIB = 1'b0,
        LFSR_GAL = 1'b1
    } lfsr_mode_e;

    // Reset tap mask (x^16 + x^15 + x^13 + x^4 + 1) and reset seed, 16-bit form
    localparam logic [15:0] LFSR_TAPS_DEFAULT = 16'hD008;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'h0001;

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_step.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_step
//  Description : One combinational LFSR shift, Fibonacci or Galois form.
//                Emits the bit shifted out of the MSB and the next state.
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] state_in,
    input  logic [WIDTH-1:0] taps,
    input  lfsr_mode_e       mode,
    output logic [WIDTH-1:0] state_out,
    output logic             bit_out
);

    logic fib_fb;

    // The generated bit is always the MSB before the shift
    assign bit_out = state_in[WIDTH-1];

    // Fibonacci feedback is the parity of the tapped bits
    assign fib_fb  = ^(state_in & taps);

    // Select the next state for the active topology
    always_comb begin
        state_out = {state_in[WIDTH-2:0], fib_fb};
        if (mode == LFSR_GAL) begin
            // Galois: shift left, then fold the outgoing bit back through the taps
            state_out = {state_in[WIDTH-2:0], 1'b0} ^ (bit_out ? taps : '0);
        end
    end

endmodule : lfsr_step
`default_nettype wire

// File: rtl/lfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_gen
//  Description : LFSR word generator. OUT_W single steps are chained so a
//                whole output word is produced per cycle, delivered through a
//                valid/ready handshake with lock-up recovery and word counter.
//  Revision    : 1.0  initial release
// ============================================================================
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter int               OUT_W        = 8,
    parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(LFSR_SEED_DEFAULT),
    parameter logic [WIDTH-1:0] TAPS_DEFAULT = WIDTH'(LFSR_TAPS_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] taps,
    input  logic             mode,
    input  logic             en,
    output logic [OUT_W-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [WIDTH-1:0] state,
    output logic             lockup,
    output logic [15:0]      word_cnt
);

    // Substitute state used whenever the register would otherwise become all zero
    localparam logic [WIDTH-1:0] STATE_ONE = WIDTH'(1);

    logic [WIDTH-1:0] taps_q;
    lfsr_mode_e       mode_q;

    logic [OUT_W-1:0] gen_bits;
    logic [WIDTH-1:0] gen_state;
    logic             gen_zero;
    logic             seed_zero;
    logic             gen_go;
    logic             accept;

    // Chain of single steps; stage i produces output bit OUT_W-1-i (MSB first)
    for (genvar i = 0; i < OUT_W; i++) begin : g_step
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] nxt;
        logic             bit_o;

        if (i == 0) begin : g_first
            assign cur = state;
        end else begin : g_next
            assign cur = g_step[i-1].nxt;
        end

        lfsr_step #(
            .WIDTH (WIDTH)
        ) u_step (
            .state_in  (cur),
            .taps      (taps_q),
            .mode      (mode_q),
            .state_out (nxt),
            .bit_out   (bit_o)
        );

        assign gen_bits[OUT_W-1-i] = bit_o;
    end

    assign gen_state = g_step[OUT_W-1].nxt;
    assign gen_zero  = (gen_state == '0);
    assign seed_zero = (seed == '0);

    // A new word may be produced when the output slot is free or being emptied
    assign gen_go    = en && (!dout_valid || dout_ready);
    assign accept    = dout_valid && dout_ready;

    // LFSR state, configuration, output word and lock-up flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEED_DEFAULT;
            taps_q     <= TAPS_DEFAULT;
            mode_q     <= LFSR_FIB;
            dout       <= '0;
            dout_valid <= 1'b0;
            lockup     <= 1'b0;
        end else if (load) begin
            // Load wins over everything; a pending word is simply dropped
            state      <= seed_zero ? STATE_ONE : seed;
            taps_q     <= taps;
            mode_q     <= lfsr_mode_e'(mode);
            dout_valid <= 1'b0;
            lockup     <= seed_zero;
        end else if (gen_go) begin
            state      <= gen_zero ? STATE_ONE : gen_state;
            dout       <= gen_bits;
            dout_valid <= 1'b1;
            if (gen_zero) begin
                lockup <= 1'b1;
            end
        end else if (accept) begin
            dout_valid <= 1'b0;
        end
    end

    // Count accepted words; cleared by load so a discarded word is never counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (load) begin
            word_cnt <= '0;
        end else if (accept) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end

endmodule : lfsr_gen
`default_nettype wire

// File: tb/tb_lfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_gen
//  Description : Self-checking bench for lfsr_gen (WIDTH=16, OUT_W=8).
//                A behavioural model predicts each cycle; expected words and
//                register snapshots go into queues consumed by monitors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lfsr_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] seed;
    logic [15:0] taps;
    logic        mode;
    logic        en;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [15:0] state;
    logic        lockup;
    logic [15:0] word_cnt;

    lfsr_gen #(
        .WIDTH (16),
        .OUT_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .seed       (seed),
        .taps       (taps),
        .mode       (mode),
        .en         (en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .state      (state),
        .lockup     (lockup),
        .word_cnt   (word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] st;
        logic [15:0] cnt;
        logic        lk;
        logic        vld;
    } snap_t;

    snap_t      snap_q[$];
    logic [7:0] word_q[$];

    int vectors     = 0;
    int miscompares = 0;
    bit checking    = 1'b0;

    // Reference model registers
    logic [15:0] m_state;
    logic [15:0] m_taps;
    logic        m_mode;
    logic        m_valid;
    logic [15:0] m_cnt;
    logic        m_lock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Produce one 8-bit word by stepping the register bit by bit with plain arithmetic
    function automatic void ref_word(input logic [15:0] s, input logic [15:0] tp, input bit md,
                                     output logic [7:0] w, output logic [15:0] ns);
        int x;
        int b;
        int acc;
        x   = int'(s);
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            b   = (x / 32768) % 2;
            acc = acc * 2 + b;
            if (!md) x = ((x * 2) % 65536) + ($countones(16'(x) & tp) % 2);
            else     x = ((x * 2) % 65536) ^ (b == 1 ? int'(tp) : 0);
        end
        w  = 8'(acc);
        ns = 16'(x);
    endfunction

    task automatic model_reset();
        m_state = 16'h0001;
        m_taps  = 16'hD008;
        m_mode  = 1'b0;
        m_valid = 1'b0;
        m_cnt   = 16'h0000;
        m_lock  = 1'b0;
        word_q.delete();
        snap_q.delete();
    endtask

    // Drive one cycle of stimulus and predict its effect at the next rising edge
    task automatic cycle(input bit ld, input logic [15:0] sd, input logic [15:0] tp,
                         input bit md, input bit e, input bit r);
        logic [7:0]  w;
        logic [15:0] ns;
        @(negedge clk);
        load = ld; seed = sd; taps = tp; mode = md; en = e; dout_ready = r;
        if (ld) begin
            word_q.delete();
            m_taps  = tp;
            m_mode  = md;
            m_valid = 1'b0;
            m_cnt   = 16'h0000;
            m_lock  = (sd == 16'h0000);
            m_state = (sd == 16'h0000) ? 16'h0001 : sd;
        end else begin
            if (m_valid && r) m_cnt = m_cnt + 16'd1;
            if (e && (!m_valid || r)) begin
                ref_word(m_state, m_taps, m_mode, w, ns);
                if (ns == 16'h0000) begin
                    ns     = 16'h0001;
                    m_lock = 1'b1;
                end
                m_state = ns;
                m_valid = 1'b1;
                word_q.push_back(w);
            end else if (m_valid && r) begin
                m_valid = 1'b0;
            end
        end
        snap_q.push_back('{st: m_state, cnt: m_cnt, lk: m_lock, vld: m_valid});
    endtask

    // Word monitor: compare every accepted word against the oldest prediction
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (checking && rst_n && dout_valid && dout_ready && !load) begin
                if (word_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL word_queue: got word %0h, expected none pending", dout);
                end else begin
                    chk("dout", 64'(dout), 64'(word_q.pop_front()));
                end
            end
        end
    end

    // Register monitor: compare visible state after each edge against the model
    initial begin
        snap_t s;
        forever begin
            @(posedge clk);
            #1;
            if (checking && snap_q.size() > 0) begin
                s = snap_q.pop_front();
                chk("state",      64'(state),      64'(s.st));
                chk("dout_valid", 64'(dout_valid), 64'(s.vld));
                chk("word_cnt",   64'(word_cnt),   64'(s.cnt));
                chk("lockup",     64'(lockup),     64'(s.lk));
            end
        end
    end

    initial begin
        logic [15:0] saved_state;
        int          first_ret;

        rst_n = 1'b1; load = 1'b0; seed = '0; taps = '0; mode = 1'b0; en = 1'b0; dout_ready = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("rst_state",    64'(state),      64'h0001);
        chk("rst_dout",     64'(dout),       64'h00);
        chk("rst_valid",    64'(dout_valid), 64'h0);
        chk("rst_lockup",   64'(lockup),     64'h0);
        chk("rst_word_cnt", 64'(word_cnt),   64'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        checking = 1'b1;

        // Reset-default configuration runs straight away
        repeat (4) cycle(0, 16'h0, 16'h0, 0, 1, 1);

        // Rotation with a single tap: words 00, A5, 00 ...
        cycle(1, 16'h00A5, 16'h8000, 0, 0, 0);
        cycle(0, 16'h0, 16'h0, 0, 1, 1);
        @(posedge clk); #1;
        chk("rot_state1", 64'(state), 64'hA500);
        chk("rot_word1",  64'(dout),  64'h00);
        cycle(0, 16'h0, 16'h0, 0, 1, 1);
        @(posedge clk); #1;
        chk("rot_word2",  64'(dout),  64'hA5);
        repeat (4) cycle(0, 16'h0, 16'h0, 0, 1, 1);

        // Zero taps collapse to the all-zero state on the second word
        cycle(1, 16'h0001, 16'h0000, 0, 0, 0);
        cycle(0, 16'h0, 16'h0, 0, 1, 1);
        cycle(0, 16'h0, 16'h0, 0, 1, 1);
        @(posedge clk); #1;
        chk("lock_state", 64'(state),  64'h0001);
        chk("lock_flag",  64'(lockup), 64'h1);
        repeat (5) cycle(0, 16'h0, 16'h0, 0, 1, 1);
        cycle(1, 16'h0000, 16'h0000, 0, 0, 1);
        @(posedge clk); #1;
        chk("lock_zero_seed", 64'(lockup), 64'h1);
        cycle(1, 16'h0042, 16'hD008, 0, 0, 1);
        @(posedge clk); #1;
        chk("lock_cleared", 64'(lockup), 64'h0);

        // Stall for three cycles, then release
        cycle(1, 16'h1234, 16'hD008, 0, 0, 0);
        cycle(0, 16'h0, 16'h0, 0, 1, 0);
        saved_state = m_state;
        repeat (3) cycle(0, 16'h0, 16'h0, 0, 1, 0);
        @(posedge clk); #1;
        chk("stall_state", 64'(state),    64'(saved_state));
        chk("stall_cnt",   64'(word_cnt), 64'h0);
        chk("stall_valid", 64'(dout_valid), 64'h1);
        cycle(0, 16'h0, 16'h0, 0, 0, 1);
        @(posedge clk); #1;
        chk("stall_release_cnt", 64'(word_cnt), 64'h1);

        // Load with a word pending and the consumer stalled
        cycle(0, 16'h0, 16'h0, 0, 1, 0);
        cycle(1, 16'hBEEF, 16'hD008, 1, 1, 0);
        @(posedge clk); #1;
        chk("ldpend_valid", 64'(dout_valid), 64'h0);
        chk("ldpend_cnt",   64'(word_cnt),   64'h0);
        chk("ldpend_state", 64'(state),      64'hBEEF);

        // Randomised traffic with occasional reloads in both modes
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                cycle(1, ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom),
                      16'($urandom) | 16'h0001, 1'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                cycle(0, 16'($urandom), 16'($urandom), 1'($urandom),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            end
        end

        // Full period of the default maximal-length polynomial
        cycle(1, 16'h0001, 16'hD008, 0, 0, 1);
        first_ret = 0;
        for (int i = 1; i <= 65535; i++) begin
            cycle(0, 16'h0, 16'h0, 0, 1, 1);
            @(posedge clk); #1;
            if (first_ret == 0 && state == 16'h0001) first_ret = i;
        end
        chk("period_first_return", 64'(first_ret), 64'd65535);
        cycle(0, 16'h0, 16'h0, 0, 0, 1);
        @(posedge clk); #1;
        chk("period_word_cnt", 64'(word_cnt), 64'd65535);
        chk("period_lockup",   64'(lockup),   64'h0);

        // Asynchronous reset mid-stream with lockup set
        cycle(1, 16'h0000, 16'h8000, 0, 0, 1);
        repeat (3) cycle(0, 16'h0, 16'h0, 0, 1, 1);
        #2;
        rst_n = 1'b0;
        load = 1'b0; en = 1'b0; dout_ready = 1'b0;
        model_reset();
        #1;
        chk("async_state",  64'(state),      64'h0001);
        chk("async_dout",   64'(dout),       64'h00);
        chk("async_valid",  64'(dout_valid), 64'h0);
        chk("async_lockup", 64'(lockup),     64'h0);
        chk("async_cnt",    64'(word_cnt),   64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) cycle(0, 16'h0, 16'h0, 0, 1, 1);

        @(negedge clk);
        #3;
        chk("words_drained_or_pending", 64'(word_q.size() <= 1), 64'h1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_lfsr_gen
`default_nettype wire
